// File: rtl/ahblite_sram_slave.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM with 1-cycle read latency.
// Zero-wait reads/writes, one wait state for a read right after a write, two-cycle ERROR.
module ahblite_sram_slave #(
    parameter int HADDR_W = 28,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hsel_i,
    input  logic [HADDR_W-1:0] haddr_i,
    input  logic [1:0]         htrans_i,
    input  logic [2:0]         hsize_i,
    input  logic               hwrite_i,
    input  logic [DATA_W-1:0]  hwdata_i,
    input  logic [2:0]         hburst_i,
    input  logic [3:0]         hprot_i,
    input  logic               hmastlock_i,
    output logic [DATA_W-1:0]  hrdata_o,
    output logic               hready_o,
    output logic               hresp_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [3:0]         sram_be_o,
    output logic [DATA_W-1:0]  sram_wdata_o,
    input  logic [DATA_W-1:0]  sram_rdata_i
);

    localparam int ROW_LSB = SRAM_AW + 2;

    // Each state names the data phase of the previously accepted transfer.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_STALL,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e             state_q, state_d;
    logic [SRAM_AW-1:0] addr_q;
    logic [3:0]         be_q;

    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic               illegal;
    logic [SRAM_AW-1:0] dec_addr;
    logic [3:0]         dec_be;

    logic unused_sideband;
    assign unused_sideband = ^{hburst_i, hprot_i, hmastlock_i};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    always_comb begin
        misaligned = 1'b0;
        case (hsize_i)
            3'b001:  misaligned = haddr_i[0];
            3'b010:  misaligned = |haddr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (haddr_i >> ROW_LSB) != '0;
    assign illegal      = (hsize_i > 3'b010) | misaligned | out_of_range;
    assign dec_addr     = haddr_i[SRAM_AW+1:2];

    always_comb begin
        dec_be = 4'b1111;
        case (hsize_i)
            3'b000:  dec_be = 4'b0001 << haddr_i[1:0];
            3'b001:  dec_be = 4'b0011 << haddr_i[1:0];
            default: dec_be = 4'b1111;
        endcase
    end

    assign hready_o = !(state_q inside {S_RD_STALL, S_ERR1});

    // Nothing is accepted while reset is held, so the SRAM port stays quiet in reset.
    assign accept = rst_ni & hsel_i & htrans_i[1] & hready_o;

    // ------------------------------------------------------------------
    // State and address-phase registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !illegal) begin
                addr_q <= dec_addr;
                be_q   <= dec_be;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and data-phase outputs
    // ------------------------------------------------------------------
    // NOTE: every output is given a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = S_IDLE;
        hresp_o      = 1'b0;
        hrdata_o     = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;

        case (state_q)
            S_WR: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = addr_q;
                sram_be_o    = be_q;
                sram_wdata_o = hwdata_i;
            end
            S_RD: begin
                hrdata_o = sram_rdata_i;
            end
            S_RD_STALL: begin
                sram_req_o  = 1'b1;
                sram_addr_o = addr_q;
            end
            S_ERR1, S_ERR2: begin
                hresp_o = 1'b1;
            end
            default: ;
        endcase

        if (state_q == S_RD_STALL) begin
            state_d = S_RD;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (!accept) begin
            state_d = S_IDLE;
        end else if (illegal) begin
            state_d = S_ERR1;
        end else if (hwrite_i) begin
            state_d = S_WR;
        end else if (state_q == S_WR) begin
            // The port is committing the write this cycle; the read issues next cycle.
            state_d = S_RD_STALL;
        end else begin
            state_d     = S_RD;
            sram_req_o  = 1'b1;
            sram_addr_o = dec_addr;
        end
    end

`ifndef SYNTHESIS
    a_err1_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == S_ERR1 |-> !sram_req_o);
    a_err_pair: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == S_ERR1 |=> state_q == S_ERR2);
    a_stall_once: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == S_RD_STALL |=> state_q == S_RD);
    a_wr_lanes_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(sram_req_o && sram_we_o) |-> (sram_be_o == '0 && sram_wdata_o == '0));
`endif

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Self-checking bench for ahblite_sram_slave: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model with its own reference memory.
module tb_ahblite_sram_slave;

    localparam int HADDR_W    = 28;
    localparam int DATA_W     = 32;
    localparam int SRAM_AW    = 12;
    localparam int SRAM_WORDS = 1 << SRAM_AW;

    typedef enum logic [1:0] {K_NONE, K_WR, K_RD, K_ERR} kind_e;

    logic               clk_i;
    logic               rst_ni;
    logic               hsel_i;
    logic [HADDR_W-1:0] haddr_i;
    logic [1:0]         htrans_i;
    logic [2:0]         hsize_i;
    logic               hwrite_i;
    logic [DATA_W-1:0]  hwdata_i;
    logic [2:0]         hburst_i;
    logic [3:0]         hprot_i;
    logic               hmastlock_i;
    logic [DATA_W-1:0]  hrdata_o;
    logic               hready_o;
    logic               hresp_o;
    logic               sram_req_o;
    logic               sram_we_o;
    logic [SRAM_AW-1:0] sram_addr_o;
    logic [3:0]         sram_be_o;
    logic [DATA_W-1:0]  sram_wdata_o;
    logic [DATA_W-1:0]  sram_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the DUT collected by the compare process for the directed checks.
    int          obs_wait = 0;
    int          obs_err  = 0;
    int          obs_req  = 0;
    int          obs_rd   = 0;
    logic [31:0] obs_rdata = '0;
    logic [3:0]  obs_be    = '0;

    // Reference model state: the data-phase transfer and its own copy of memory.
    kind_e       m_kind = K_NONE;
    int          m_cyc  = 0;
    logic        m_stall = 1'b0;
    logic [11:0] m_addr = '0;
    logic [3:0]  m_be   = '0;
    logic [31:0] ref_mem [SRAM_WORDS];

    logic [31:0] sram_mem [SRAM_WORDS];
    logic        sram_init_done = 1'b0;
    logic [31:0] pend_wdata = '0;

    ahblite_sram_slave #(
        .HADDR_W(HADDR_W),
        .DATA_W (DATA_W),
        .SRAM_AW(SRAM_AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .hsel_i      (hsel_i),
        .haddr_i     (haddr_i),
        .htrans_i    (htrans_i),
        .hsize_i     (hsize_i),
        .hwrite_i    (hwrite_i),
        .hwdata_i    (hwdata_i),
        .hburst_i    (hburst_i),
        .hprot_i     (hprot_i),
        .hmastlock_i (hmastlock_i),
        .hrdata_o    (hrdata_o),
        .hready_o    (hready_o),
        .hresp_o     (hresp_o),
        .sram_req_o  (sram_req_o),
        .sram_we_o   (sram_we_o),
        .sram_addr_o (sram_addr_o),
        .sram_be_o   (sram_be_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous SRAM behind the DUT, same initial image as the reference memory.
    always @(posedge clk_i) begin
        if (!sram_init_done) begin
            for (int i = 0; i < SRAM_WORDS; i++) sram_mem[i] <= init_word(i);
            sram_rdata_i   <= '0;
            sram_init_done <= 1'b1;
        end else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    // Compare process: bus-level expectations from the data-phase transfer, every cycle.
    initial begin : compare
        logic        erdy, eresp, prev_wr, bad;
        logic [31:0] erdata;
        int          sz, lo;
        for (int i = 0; i < SRAM_WORDS; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                m_kind = K_NONE;
                m_cyc  = 0;
                check("rst_hready",   32'(hready_o),   32'd1);
                check("rst_hresp",    32'(hresp_o),    32'd0);
                check("rst_hrdata",   hrdata_o,        32'd0);
                check("rst_sram_req", 32'(sram_req_o), 32'd0);
                check("rst_sram_we",  32'(sram_we_o),  32'd0);
            end else begin
                erdy = 1'b1; eresp = 1'b0; erdata = '0;
                case (m_kind)
                    K_RD:  if (m_stall && m_cyc == 0) erdy = 1'b0; else erdata = ref_mem[m_addr];
                    K_ERR: begin eresp = 1'b1; erdy = (m_cyc != 0); end
                    default: ;
                endcase
                check("hready", 32'(hready_o), 32'(erdy));
                check("hresp",  32'(hresp_o),  32'(eresp));
                check("hrdata", hrdata_o,      erdata);
                if (m_kind == K_WR) begin
                    check("wr_req",   32'(sram_req_o),  32'd1);
                    check("wr_we",    32'(sram_we_o),   32'd1);
                    check("wr_addr",  32'(sram_addr_o), 32'(m_addr));
                    check("wr_be",    32'(sram_be_o),   32'(m_be));
                    check("wr_wdata", sram_wdata_o,     hwdata_i);
                    obs_be = sram_be_o;
                end
                if (m_kind == K_ERR && m_cyc == 0) check("err1_no_sram", 32'(sram_req_o), 32'd0);
                if (!(sram_req_o && sram_we_o)) begin
                    check("quiet_be",    32'(sram_be_o), 32'd0);
                    check("quiet_wdata", sram_wdata_o,   32'd0);
                end
                if (!hready_o)   obs_wait++;
                if (hresp_o)     obs_err++;
                if (sram_req_o)  obs_req++;
                if (m_kind == K_RD && erdy) begin obs_rdata = hrdata_o; obs_rd++; end

                if (erdy) begin
                    if (m_kind == K_WR)
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) ref_mem[m_addr][8*b +: 8] = hwdata_i[8*b +: 8];
                    prev_wr = (m_kind == K_WR);
                    m_kind  = K_NONE;
                    if (hsel_i && htrans_i[1]) begin
                        sz  = int'(hsize_i);
                        lo  = int'(haddr_i[1:0]);
                        bad = (sz > 2) || ((lo % (1 << sz)) != 0) || (int'(haddr_i) >= (1 << (SRAM_AW + 2)));
                        if (bad) begin
                            m_kind = K_ERR;
                        end else begin
                            m_addr  = 12'(haddr_i >> 2);
                            for (int b = 0; b < 4; b++) m_be[b] = (b >= lo) && (b < lo + (1 << sz));
                            m_kind  = hwrite_i ? K_WR : K_RD;
                            m_stall = prev_wr;
                        end
                    end
                    m_cyc = 0;
                end else begin
                    m_cyc++;
                end
            end
        end
    end

    // One address phase, held until the DUT samples it with hready high (bounded).
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [27:0] addr, input logic [31:0] wd);
        logic rdy;
        int   n;
        hsel_i   = sel;
        htrans_i = trans;
        hwrite_i = wr;
        hsize_i  = size;
        haddr_i  = addr;
        hwdata_i = pend_wdata;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 8) begin
            @(negedge clk_i);
            rdy = hready_o;
            @(posedge clk_i);
            n++;
        end
        check("hready_within_budget", 32'(rdy), 32'd1);
        pend_wdata = wd;
        #1;
    endtask

    task automatic idle();
        xfer(1'b0, 2'b00, 1'b0, 3'b010, 28'h0, 32'h0);
    endtask

    task automatic reset_pulse();
        rst_ni   = 1'b0;
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin : main
        int          base_w, base_e, base_r, base_rd, diff;
        logic [31:0] w;
        rst_ni      = 1'b0;
        hsel_i      = 1'b0;
        haddr_i     = '0;
        htrans_i    = 2'b00;
        hsize_i     = 3'b010;
        hwrite_i    = 1'b0;
        hwdata_i    = '0;
        hburst_i    = 3'b000;
        hprot_i     = 4'b0011;
        hmastlock_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // 1: word write, idle gap, read back
        xfer(1'b1, 2'b10, 1'b1, 3'b010, 28'h10, 32'hDEADBEEF);
        idle();
        base_e = obs_err;
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h10, 32'h0);
        idle();
        check("t1_rdata", obs_rdata, 32'hDEADBEEF);
        check("t1_no_error", 32'(obs_err - base_e), 32'd0);

        // 2: write immediately followed by read of the same word
        base_w = obs_wait;
        xfer(1'b1, 2'b10, 1'b1, 3'b010, 28'h20, 32'hCAFEF00D);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h20, 32'h0);
        idle();
        check("t2_wait_states", 32'(obs_wait - base_w), 32'd1);
        check("t2_rdata", obs_rdata, 32'hCAFEF00D);

        // 3: byte lane 1, then upper half, then word read
        xfer(1'b1, 2'b10, 1'b1, 3'b000, 28'h31, 32'h0000AA00);
        xfer(1'b1, 2'b10, 1'b1, 3'b001, 28'h32, 32'h12340000);
        check("t3_byte_be", 32'(obs_be), 32'h2);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h30, 32'h0);
        check("t3_half_be", 32'(obs_be), 32'hC);
        idle();
        w = init_word(12);
        check("t3_rdata", obs_rdata, {24'h1234AA, w[7:0]});
        check("t3_model", ref_mem[12], {24'h1234AA, w[7:0]});

        // 4: pipelined reads
        base_w  = obs_wait;
        base_rd = obs_rd;
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h0, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h4, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h8, 32'h0);
        idle();
        check("t4_wait_states", 32'(obs_wait - base_w), 32'd0);
        check("t4_reads_done",  32'(obs_rd - base_rd),  32'd3);
        check("t4_last_rdata",  obs_rdata, init_word(2));

        // 5: illegal transfers back to back
        base_w = obs_wait;
        base_e = obs_err;
        base_r = obs_req;
        xfer(1'b1, 2'b10, 1'b1, 3'b001, 28'h1,    32'hFFFFFFFF);
        xfer(1'b1, 2'b10, 1'b0, 3'b011, 28'h0,    32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h4000, 32'h0);
        idle();
        check("t5_wait_states", 32'(obs_wait - base_w), 32'd3);
        check("t5_error_cycles", 32'(obs_err - base_e), 32'd6);
        check("t5_no_sram", 32'(obs_req - base_r), 32'd0);

        // 6: reset while the read after a write is stalled
        xfer(1'b1, 2'b10, 1'b1, 3'b010, 28'h40, 32'h55AA1234);
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h40, 32'h0);
        check("t6_in_stall", 32'(hready_o), 32'd0);
        rst_ni   = 1'b0;
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        @(negedge clk_i);
        check("t6_reset_hready", 32'(hready_o), 32'd1);
        check("t6_reset_req", 32'(sram_req_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        base_w = obs_wait;
        xfer(1'b1, 2'b10, 1'b0, 3'b010, 28'h40, 32'h0);
        idle();
        check("t6_zero_wait", 32'(obs_wait - base_w), 32'd0);
        check("t6_rdata", obs_rdata, 32'h55AA1234);

        // Randomized traffic over a small window so reads hit earlier writes
        for (int it = 0; it < 600; it++) begin
            logic        s, wr;
            logic [1:0]  t;
            logic [2:0]  z;
            logic [27:0] a;
            int          r;
            if (it % 200 == 199) reset_pulse();
            s  = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 19);
            t  = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 12) ? 2'b10 : 2'b11;
            wr = 1'($urandom_range(0, 1));
            z  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 28'(32'h100 + 4 * $urandom_range(0, 15));
            r  = $urandom_range(0, 39);
            if (r == 0)      a[1:0] = 2'($urandom_range(1, 3));
            else if (r == 1) a = a | (28'd1 << $urandom_range(14, 27));
            else if (z == 3'b000) a[1:0] = 2'($urandom_range(0, 3));
            else if (z == 3'b001) a[1] = 1'($urandom_range(0, 1));
            xfer(s, t, wr, z, a, $urandom);
        end
        idle();
        idle();

        diff = 0;
        for (int i = 0; i < SRAM_WORDS; i++)
            if (sram_mem[i] !== ref_mem[i]) diff++;
        check("final_mem_words_differing", 32'(diff), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
